// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low abcdefg patterns (index 0 = a) and reader result codes.
package seg7_pkg;

  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rd_state_t;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Exact-match reverse lookup of an active-low 7-segment pattern into a BCD digit, blank or error.
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [0:6] pattern,
  output logic [3:0] digit,
  output logic       blank,
  output logic       err
);

  always_comb begin
    digit = CODE_ERR;
    blank = 1'b0;
    err   = 1'b0;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: begin
        digit = CODE_BLANK;
        blank = 1'b1;
      end
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Recovers the digit shown on an asynchronous active-low 7-segment bus; each newly settled
// pattern is offered once on a valid/ready output.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic [0:6] SEG_N,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_digit,
  output logic       out_blank,
  output logic       out_err,
  output logic       ovf
);

  localparam int CNT_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_EVT = CNT_W'(STABLE_CYCLES - 1);

  logic [0:6]       seg_p0;
  logic [0:6]       seg_p1;
  logic [0:6]       seg_p2;
  logic [0:6]       last_loaded;
  logic [CNT_W-1:0] cnt;
  logic             stable_evt;

  rd_state_t        state;
  rd_state_t        state_nxt;
  logic             load;
  logic             set_ovf;

  logic [3:0]       lk_digit;
  logic             lk_blank;
  logic             lk_err;

  // Stage p0/p1: two-flop synchroniser on the asynchronous segment lines
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      seg_p0 <= SEG_BLANK;
      seg_p1 <= SEG_BLANK;
    end else begin
      seg_p0 <= SEG_N;
      seg_p1 <= seg_p0;
    end
  end

  // Stage p2: previous sample and settle counter; counter starts saturated so
  // the blank display seen straight after reset never looks like a new pattern
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      seg_p2 <= SEG_BLANK;
      cnt    <= CNT_MAX;
    end else begin
      seg_p2 <= seg_p1;
      if (seg_p1 != seg_p2) begin
        cnt <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Fires only on the saturating step, so each stable episode yields at most one event.
  assign stable_evt = (seg_p1 == seg_p2) && (cnt == CNT_EVT) && (seg_p1 != last_loaded);

  seg7_pattern_lookup u_lookup (
    .pattern (seg_p1),
    .digit   (lk_digit),
    .blank   (lk_blank),
    .err     (lk_err)
  );

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    set_ovf   = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (stable_evt) begin
          load      = 1'b1;
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (stable_evt) begin
            load = 1'b1;
          end else begin
            state_nxt = ST_EMPTY;
          end
        end else if (stable_evt) begin
          set_ovf = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Result hold registers; a dropped event leaves last_loaded untouched
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      out_digit   <= CODE_BLANK;
      out_blank   <= 1'b1;
      out_err     <= 1'b0;
      last_loaded <= SEG_BLANK;
      ovf         <= 1'b0;
    end else begin
      if (load) begin
        out_digit   <= lk_digit;
        out_blank   <= lk_blank;
        out_err     <= lk_err;
        last_loaded <= seg_p1;
      end
      if (set_ovf) begin
        ovf <= 1'b1;
      end
    end
  end

  assign out_valid = (state == ST_FULL);

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: settle latency, glitch rejection, repeat suppression, overflow and reset.
module tb_seg7_reader;

  logic       clk;
  logic       rst_n;
  logic [0:6] seg_n;
  logic       ready;
  logic       valid;
  logic [3:0] digit;
  logic       blank;
  logic       err;
  logic       ovf;

  int nvec = 0;
  int nerr = 0;

  seg7_reader #(.STABLE_CYCLES(4)) dut (
    .CLOCK_50  (clk),
    .Resetn    (rst_n),
    .SEG_N     (seg_n),
    .out_ready (ready),
    .out_valid (valid),
    .out_digit (digit),
    .out_blank (blank),
    .out_err   (err),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Edges (counted from the drive point) until out_valid is seen; -1 on timeout.
  task automatic wait_valid(input int maxe, output int edges);
    edges = -1;
    for (int e = 1; e <= maxe; e++) begin
      @(negedge clk);
      if (valid) begin
        edges = e;
        break;
      end
    end
  endtask

  task automatic run_count(input int n, output int nev, output logic [3:0] dig, output logic er);
    nev = 0;
    dig = 4'h0;
    er  = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (valid) begin
        nev++;
        dig = digit;
        er  = err;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         e;
    int         nev;
    logic [3:0] dg;
    logic       er;
    logic       seen;

    rst_n = 1'b0;
    seg_n = 7'b1111111;
    ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_digit", digit, 4'hF);
    chk("rst_blank", blank, 1);
    chk("rst_err",   err,   0);
    chk("rst_ovf",   ovf,   0);

    // 1: blank after reset never produces an event
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    chk("t1_no_valid", seen, 0);
    chk("t1_digit", digit, 4'hF);
    chk("t1_blank", blank, 1);
    chk("t1_ovf",   ovf,   0);

    // 2: digit 2, valid at edge 7 for one cycle
    ready = 1'b1;
    seg_n = 7'b0010010;
    wait_valid(20, e);
    chk("t2_latency", e, 7);
    chk("t2_digit", digit, 4'd2);
    chk("t2_err",   err,   0);
    chk("t2_blank", blank, 0);
    @(negedge clk);
    chk("t2_one_cycle", valid, 0);

    // 3: back to blank (new vs last_loaded), then 3-cycle glitch, then settled 6
    seg_n = 7'b1111111;
    run_count(12, nev, dg, er);
    chk("t3_blank_evts", nev, 1);
    chk("t3_blank_dig",  dg,  4'hF);
    seg_n = 7'b0100000;
    repeat (3) @(negedge clk);
    seg_n = 7'b1111111;
    run_count(12, nev, dg, er);
    chk("t3_glitch_evts", nev, 0);
    seg_n = 7'b0100000;
    run_count(14, nev, dg, er);
    chk("t3_six_evts", nev, 1);
    chk("t3_six_dig",  dg,  4'd6);

    // 4: held result with dropped second event
    ready = 1'b0;
    seg_n = 7'b1001111;
    repeat (12) @(negedge clk);
    chk("t4_valid1", valid, 1);
    chk("t4_dig1",   digit, 4'd1);
    chk("t4_ovf0",   ovf,   0);
    seg_n = 7'b0001111;
    repeat (12) @(negedge clk);
    chk("t4_valid_held", valid, 1);
    chk("t4_dig_held",   digit, 4'd1);
    chk("t4_ovf1",       ovf,   1);
    ready = 1'b1;
    @(negedge clk);
    chk("t4_drain", valid, 0);
    run_count(12, nev, dg, er);
    chk("t4_no_reemit", nev, 0);
    chk("t4_ovf_sticky", ovf, 1);

    // 5: invalid, digit 0, invalid again
    seg_n = 7'b1110000;
    run_count(12, nev, dg, er);
    chk("t5_e1_evts", nev, 1);
    chk("t5_e1_dig",  dg,  4'hE);
    chk("t5_e1_err",  er,  1);
    chk("t5_e1_blank", blank, 0);
    seg_n = 7'b0000001;
    run_count(12, nev, dg, er);
    chk("t5_zero_evts", nev, 1);
    chk("t5_zero_dig",  dg,  4'd0);
    chk("t5_zero_err",  er,  0);
    seg_n = 7'b1110000;
    run_count(12, nev, dg, er);
    chk("t5_e2_evts", nev, 1);
    chk("t5_e2_dig",  dg,  4'hE);

    // 6: async reset while holding 9, then re-emission after release
    ready = 1'b0;
    seg_n = 7'b0000100;
    repeat (12) @(negedge clk);
    chk("t6_valid9", valid, 1);
    chk("t6_dig9",   digit, 4'd9);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_digit", digit, 4'hF);
    chk("t6_rst_blank", blank, 1);
    chk("t6_rst_err",   err,   0);
    chk("t6_rst_ovf",   ovf,   0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(20, e);
    chk("t6_latency", e, 7);
    chk("t6_dig", digit, 4'd9);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
